uvmt_cv32e40s_sl_trigger_csr_shadow: RTL and testbench
======================================================

// Module: uvmt_cv32e40s_sl_trigger_csr_shadow
// PURPOSE
//  Support-logic model that writes the per-trigger tdata1/tdata2 shadow arrays read by the trigger-match predictor.
//  Tracks retired CSR writes to tselect/tdata1/tdata2 from RVFI, applies WARL legalisation, and sets hit bits on fired triggers.
//  Sits beside the match predictor in the uvmt support-logic layer; outputs are driven onto in_support_if.
// PARAMETERS
//  NUM_TRIGGERS   CORE_PARAM_DBG_NUM_TRIGGERS   number of implemented triggers (1..4)
//  TDATA1_RESET   32'h2800_1000                 tdata1 reset value per trigger (type 2, dmode=1, m=0,u=0)
// PORTS
//  clk_i              in   1        clock
//  rst_ni             in   1        asynchronous active-low reset
//  rvfi_valid         in   1        instruction retires this cycle
//  rvfi_trap          in   1        retiring instruction trapped (CSR side effects suppressed)
//  rvfi_dbg_mode      in   1        retiring instruction executed in debug mode
//  tselect_wmask      in   32       RVFI CSR write mask, tselect
//  tselect_wdata      in   32       RVFI CSR write data, tselect
//  tdata1_wmask       in   32       RVFI CSR write mask, tdata1
//  tdata1_wdata       in   32       RVFI CSR write data, tdata1
//  tdata2_wmask       in   32       RVFI CSR write mask, tdata2
//  tdata2_wdata       in   32       RVFI CSR write data, tdata2
//  tdata1_rdata       in   32       RVFI CSR read data, tdata1 (check feature only)
//  trigger_fire       in   NUM_TRIGGERS  is_trigger_match from predictor, qualified by debug entry
//  tselect_o          out  32       shadow tselect
//  tdata1_array       out  NUM_TRIGGERS x 32  shadow tdata1 per trigger
//  tdata2_array       out  NUM_TRIGGERS x 32  shadow tdata2 per trigger
//  csr_mismatch       out  1        pulse: RVFI tdata1 read differs from shadow
// BEHAVIOUR
//  - Reset (async): tselect_o=0, tdata1_array[t]=TDATA1_RESET, tdata2_array[t]=0, csr_mismatch=0.
//  - Update only on clk_i rise with rvfi_valid=1 && rvfi_trap=0; results visible next cycle (1-cycle latency),
//    so the predictor sees new values from the following retirement onward.
//  - New value = (old & ~wmask) | (wdata & wmask) before legalisation.
//  - tselect: written value >= NUM_TRIGGERS -> write ignored, old value kept.
//  - tdata1/tdata2 address trigger tselect_o (value before this retirement).
//  - tdata1/tdata2 writes with rvfi_dbg_mode=0 ignored (dmode fixed 1).
//  - tdata1 legalisation on type[31:28]: 2 -> AND MCONTROL_WMASK, match[10:7] not in {0,2,3} -> 0;
//    6 -> AND MCONTROL6_WMASK, same match rule; 5 -> AND ETRIGGER_WMASK; 15 -> 32'hF800_0000;
//    any other type -> 32'hF800_0000. Bit 27 (dmode) forced 1 for types 2/5/6.
//  - tdata2: stored unmodified for all types.
//  - Hit: trigger_fire[t]=1 sets hit bit (type 6: bit 22; type 5: bit 26; type 2: bit 20) same cycle-edge;
//    a same-cycle tdata1 write to trigger t takes precedence (hit not OR-ed into written value).
//  - Simultaneous tselect and tdata writes in one retirement: tdata uses old tselect, tselect then updates.
//  - Reset asserted mid-operation: all state returns to reset values immediately; no partial write kept.
// CONFIGURATION
//  Macro UVMT_CV32E40S_SL_TRIGGER_CSR_CHECK_EN:
//   defined: on rvfi_valid with tdata1 read (rvfi_dbg_mode=1), compare tdata1_rdata vs pre-update shadow
//            of tselect_o; csr_mismatch registered high for one cycle on difference.
//   undefined: csr_mismatch tied 0, tdata1_rdata unused.
// STRUCTURE
//  - uvmt_cv32e40s_base_test_pkg: TDATA1 field LSB/MSB constants, type codes, MCONTROL_WMASK, MCONTROL6_WMASK,
//    ETRIGGER_WMASK, TDATA1_DISABLED (32'hF800_0000), function legalise_tdata1().
//  - Sub-module uvmt_cv32e40s_sl_trigger_csr_slot: one trigger's tdata1/tdata2 regs + hit logic, generated per trigger.
// TESTING
//  - Reset then idle -> tdata1_array all 32'h2800_1000, tdata2_array all 0, tselect_o=0.
//  - Debug mode: tselect=1, tdata1=32'h6800_1044 -> tdata1_array[1]=legalised type-6 value next cycle, [0] unchanged.
//  - tselect write 32'h10 with NUM_TRIGGERS=4 -> tselect_o stays at previous value.
//  - tdata1 write type 3 in debug mode -> 32'hF800_0000; same write with rvfi_dbg_mode=0 or rvfi_trap=1 -> no change.
//  - trigger_fire[0]=1 on type-6 trigger 0 -> bit 22 of tdata1_array[0] set next cycle; concurrent write wins.
//  - CHECK_EN: tdata1_rdata differs from shadow in debug mode -> csr_mismatch=1 for exactly one cycle.

Source files
------------

// File: rtl/uvmt_cv32e40s_base_test_pkg.sv
// Trigger CSR constants and the tdata1 WARL legalisation helpers shared by
// the trigger support-logic models (shadow writer and match predictor).
package uvmt_cv32e40s_base_test_pkg;

    // tdata1 field positions
    localparam int TDATA1_TYPE_MSB  = 31;
    localparam int TDATA1_TYPE_LSB  = 28;
    localparam int TDATA1_DMODE     = 27;
    localparam int TDATA1_MATCH_MSB = 10;
    localparam int TDATA1_MATCH_LSB = 7;

    // hit bit position per trigger type
    localparam int TDATA1_HIT_MCONTROL  = 20;
    localparam int TDATA1_HIT_ETRIGGER  = 26;
    localparam int TDATA1_HIT_MCONTROL6 = 22;

    typedef enum logic [3:0] {
        TTYPE_MCONTROL  = 4'd2,
        TTYPE_ETRIGGER  = 4'd5,
        TTYPE_MCONTROL6 = 4'd6,
        TTYPE_DISABLED  = 4'd15
    } tdata1_type_e;

    // Writable bits per type: type, dmode, hit, action, match, m, u, execute/store/load
    localparam logic [31:0] MCONTROL_WMASK  = 32'hF810_F7CF;
    localparam logic [31:0] MCONTROL6_WMASK = 32'hF840_F7CF;
    // type, dmode, hit, m, u, action[5:0]
    localparam logic [31:0] ETRIGGER_WMASK  = 32'hFC00_027F;
    localparam logic [31:0] TDATA1_DISABLED = 32'hF800_0000;

    // Masked CSR write merge as reported by RVFI wmask/wdata
    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] wmask,
                                              input logic [31:0] wdata);
        return (old_val & ~wmask) | (wdata & wmask);
    endfunction

    // Supported match encodings: equal, >=, <
    function automatic logic match_legal(input logic [3:0] match);
        return (match == 4'd0) || (match == 4'd2) || (match == 4'd3);
    endfunction

    function automatic logic [31:0] legalise_tdata1(input logic [31:0] val);
        logic [31:0] res;
        res = TDATA1_DISABLED;
        case (tdata1_type_e'(val[TDATA1_TYPE_MSB:TDATA1_TYPE_LSB]))
            TTYPE_MCONTROL: begin
                res = val & MCONTROL_WMASK;
                res[TDATA1_DMODE] = 1'b1;
                if (!match_legal(res[TDATA1_MATCH_MSB:TDATA1_MATCH_LSB]))
                    res[TDATA1_MATCH_MSB:TDATA1_MATCH_LSB] = 4'd0;
            end
            TTYPE_MCONTROL6: begin
                res = val & MCONTROL6_WMASK;
                res[TDATA1_DMODE] = 1'b1;
                if (!match_legal(res[TDATA1_MATCH_MSB:TDATA1_MATCH_LSB]))
                    res[TDATA1_MATCH_MSB:TDATA1_MATCH_LSB] = 4'd0;
            end
            TTYPE_ETRIGGER: begin
                res = val & ETRIGGER_WMASK;
                res[TDATA1_DMODE] = 1'b1;
            end
            default: res = TDATA1_DISABLED;
        endcase
        return res;
    endfunction

    // Hit bit to set when a trigger of the given type fires (none if disabled)
    function automatic logic [31:0] hit_mask(input logic [3:0] ttype);
        logic [31:0] m;
        m = '0;
        case (tdata1_type_e'(ttype))
            TTYPE_MCONTROL:  m[TDATA1_HIT_MCONTROL]  = 1'b1;
            TTYPE_ETRIGGER:  m[TDATA1_HIT_ETRIGGER]  = 1'b1;
            TTYPE_MCONTROL6: m[TDATA1_HIT_MCONTROL6] = 1'b1;
            default:         m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uvmt_cv32e40s_sl_trigger_csr_shadow_if.sv
// RVFI CSR write stream in, per-trigger shadow tselect/tdata1/tdata2 out.
// master: the RVFI/predictor side; slave: the shadow model.
interface uvmt_cv32e40s_sl_trigger_csr_shadow_if #(
    parameter int unsigned NUM_TRIGGERS = 4
);
    logic                           rvfi_valid;
    logic                           rvfi_trap;
    logic                           rvfi_dbg_mode;
    logic [31:0]                    tselect_wmask;
    logic [31:0]                    tselect_wdata;
    logic [31:0]                    tdata1_wmask;
    logic [31:0]                    tdata1_wdata;
    logic [31:0]                    tdata2_wmask;
    logic [31:0]                    tdata2_wdata;
    logic [31:0]                    tdata1_rdata;
    logic [NUM_TRIGGERS-1:0]        trigger_fire;
    logic [31:0]                    tselect_o;
    logic [NUM_TRIGGERS-1:0][31:0]  tdata1_array;
    logic [NUM_TRIGGERS-1:0][31:0]  tdata2_array;
    logic                           csr_mismatch;

    modport master (
        output rvfi_valid, rvfi_trap, rvfi_dbg_mode,
        output tselect_wmask, tselect_wdata,
        output tdata1_wmask, tdata1_wdata, tdata2_wmask, tdata2_wdata,
        output tdata1_rdata, trigger_fire,
        input  tselect_o, tdata1_array, tdata2_array, csr_mismatch
    );

    modport slave (
        input  rvfi_valid, rvfi_trap, rvfi_dbg_mode,
        input  tselect_wmask, tselect_wdata,
        input  tdata1_wmask, tdata1_wdata, tdata2_wmask, tdata2_wdata,
        input  tdata1_rdata, trigger_fire,
        output tselect_o, tdata1_array, tdata2_array, csr_mismatch
    );
endinterface

// File: rtl/uvmt_cv32e40s_sl_trigger_csr_slot.sv
// One trigger's shadow tdata1/tdata2. A qualified tdata1 write is merged,
// legalised and stored; otherwise a fire sets the type-specific hit bit.
module uvmt_cv32e40s_sl_trigger_csr_slot
    import uvmt_cv32e40s_base_test_pkg::*;
#(
    parameter logic [31:0] TDATA1_RESET = 32'h2800_1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tdata1_we,
    input  logic [31:0] tdata1_wmask,
    input  logic [31:0] tdata1_wdata,
    input  logic        tdata2_we,
    input  logic [31:0] tdata2_wmask,
    input  logic [31:0] tdata2_wdata,
    input  logic        fire,
    output logic [31:0] tdata1,
    output logic [31:0] tdata2
);
    logic [31:0] tdata1_reg, tdata1_next;
    logic [31:0] tdata2_reg, tdata2_next;

    // Next-state: a write wins over a same-edge hit so the hit is not merged in
    always_comb begin
        tdata1_next = tdata1_reg;
        tdata2_next = tdata2_reg;
        if (tdata1_we)
            tdata1_next = legalise_tdata1(csr_merge(tdata1_reg, tdata1_wmask, tdata1_wdata));
        else if (fire)
            tdata1_next = tdata1_reg | hit_mask(tdata1_reg[TDATA1_TYPE_MSB:TDATA1_TYPE_LSB]);
        if (tdata2_we)
            tdata2_next = csr_merge(tdata2_reg, tdata2_wmask, tdata2_wdata);
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tdata1_reg <= TDATA1_RESET;
            tdata2_reg <= '0;
        end else begin
            tdata1_reg <= tdata1_next;
            tdata2_reg <= tdata2_next;
        end
    end

    assign tdata1 = tdata1_reg;
    assign tdata2 = tdata2_reg;
endmodule

// File: rtl/uvmt_cv32e40s_sl_trigger_csr_shadow.sv
// Shadow of the debug trigger CSRs built from retired RVFI CSR writes.
// tdata writes address the tselect value held before the retirement.
// Optional feature macro UVMT_CV32E40S_SL_TRIGGER_CSR_CHECK_EN: compares the
// RVFI tdata1 read data with the shadow and pulses csr_mismatch on difference.
module uvmt_cv32e40s_sl_trigger_csr_shadow
    import uvmt_cv32e40s_base_test_pkg::*;
#(
    parameter int unsigned NUM_TRIGGERS = 4,
    parameter logic [31:0] TDATA1_RESET = 32'h2800_1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    uvmt_cv32e40s_sl_trigger_csr_shadow_if.slave bus
);
    logic                          retire_ok;
    logic                          tdata_wr_ok;
    logic [31:0]                   tselect_reg, tselect_next, tselect_merged;
    logic [NUM_TRIGGERS-1:0][31:0] tdata1_arr;
    logic [NUM_TRIGGERS-1:0][31:0] tdata2_arr;

    assign retire_ok   = bus.rvfi_valid && !bus.rvfi_trap;
    // dmode is fixed to 1, so only debug-mode code may write tdata1/tdata2
    assign tdata_wr_ok = retire_ok && bus.rvfi_dbg_mode;

    // tselect next value: out-of-range writes leave the old selection
    always_comb begin
        tselect_merged = csr_merge(tselect_reg, bus.tselect_wmask, bus.tselect_wdata);
        tselect_next   = tselect_reg;
        if (retire_ok && (bus.tselect_wmask != '0) && (tselect_merged < 32'(NUM_TRIGGERS)))
            tselect_next = tselect_merged;
    end

    // tselect register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            tselect_reg <= '0;
        else
            tselect_reg <= tselect_next;
    end

    for (genvar gi = 0; gi < NUM_TRIGGERS; gi++) begin : g_slot
        logic slot_sel;
        assign slot_sel = tdata_wr_ok && (tselect_reg == 32'(gi));

        uvmt_cv32e40s_sl_trigger_csr_slot #(
            .TDATA1_RESET (TDATA1_RESET)
        ) u_slot (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .tdata1_we    (slot_sel && (bus.tdata1_wmask != '0)),
            .tdata1_wmask (bus.tdata1_wmask),
            .tdata1_wdata (bus.tdata1_wdata),
            .tdata2_we    (slot_sel && (bus.tdata2_wmask != '0)),
            .tdata2_wmask (bus.tdata2_wmask),
            .tdata2_wdata (bus.tdata2_wdata),
            .fire         (bus.trigger_fire[gi]),
            .tdata1       (tdata1_arr[gi]),
            .tdata2       (tdata2_arr[gi])
        );
    end

    assign bus.tselect_o    = tselect_reg;
    assign bus.tdata1_array = tdata1_arr;
    assign bus.tdata2_array = tdata2_arr;

`ifdef UVMT_CV32E40S_SL_TRIGGER_CSR_CHECK_EN
    logic [31:0] shadow_sel;
    logic        mismatch_reg, mismatch_next;

    // Compare the read data against the pre-update shadow of the selected trigger
    always_comb begin
        shadow_sel = tdata1_arr[0];
        for (int i = 0; i < int'(NUM_TRIGGERS); i++)
            if (tselect_reg == 32'(i))
                shadow_sel = tdata1_arr[i];
        mismatch_next = retire_ok && bus.rvfi_dbg_mode && (bus.tdata1_rdata != shadow_sel);
    end

    // Registered one-cycle mismatch pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            mismatch_reg <= 1'b0;
        else
            mismatch_reg <= mismatch_next;
    end

    assign bus.csr_mismatch = mismatch_reg;
`else
    logic unused_tdata1_rdata;
    assign unused_tdata1_rdata = ^bus.tdata1_rdata;
    assign bus.csr_mismatch    = 1'b0;
`endif
endmodule

// File: tb/tb_uvmt_cv32e40s_sl_trigger_csr_shadow.sv
// Directed table-driven bench for the trigger CSR shadow model, plus
// hand-written sequences for slot isolation, async reset and the read check.
module tb_uvmt_cv32e40s_sl_trigger_csr_shadow;
    localparam int NT = 4;
    localparam logic [31:0] F = 32'hFFFF_FFFF;
    localparam logic [31:0] Z = 32'h0;
    localparam logic [31:0] RST1 = 32'h2800_1000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uvmt_cv32e40s_sl_trigger_csr_shadow_if #(.NUM_TRIGGERS(NT)) bus ();

    uvmt_cv32e40s_sl_trigger_csr_shadow #(
        .NUM_TRIGGERS (NT),
        .TDATA1_RESET (32'h2800_1000)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic        valid;
        logic        trap;
        logic        dbg;
        logic [31:0] tsel_wm;
        logic [31:0] tsel_wd;
        logic [31:0] t1_wm;
        logic [31:0] t1_wd;
        logic [31:0] t2_wm;
        logic [31:0] t2_wd;
        logic [3:0]  fire;
        int          idx;
        logic [31:0] exp_tsel;
        logic [31:0] exp_t1;
        logic [31:0] exp_t2;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];
    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(input logic v, input logic t, input logic d,
                                input logic [31:0] swm, input logic [31:0] swd,
                                input logic [31:0] w1m, input logic [31:0] w1d,
                                input logic [31:0] w2m, input logic [31:0] w2d,
                                input logic [3:0] f, input int idx,
                                input logic [31:0] et, input logic [31:0] e1,
                                input logic [31:0] e2);
        vec_t r;
        r.valid = v; r.trap = t; r.dbg = d;
        r.tsel_wm = swm; r.tsel_wd = swd;
        r.t1_wm = w1m; r.t1_wd = w1d;
        r.t2_wm = w2m; r.t2_wd = w2d;
        r.fire = f; r.idx = idx;
        r.exp_tsel = et; r.exp_t1 = e1; r.exp_t2 = e2;
        return r;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, id, act, exp);
        end
    endtask

    task automatic idle();
        bus.rvfi_valid    = 1'b0;
        bus.rvfi_trap     = 1'b0;
        bus.rvfi_dbg_mode = 1'b0;
        bus.tselect_wmask = '0;
        bus.tselect_wdata = '0;
        bus.tdata1_wmask  = '0;
        bus.tdata1_wdata  = '0;
        bus.tdata2_wmask  = '0;
        bus.tdata2_wdata  = '0;
        bus.tdata1_rdata  = '0;
        bus.trigger_fire  = '0;
    endtask

    // Present one retirement, let one edge pass, then return to idle
    task automatic drive(input vec_t v);
        bus.rvfi_valid    = v.valid;
        bus.rvfi_trap     = v.trap;
        bus.rvfi_dbg_mode = v.dbg;
        bus.tselect_wmask = v.tsel_wm;
        bus.tselect_wdata = v.tsel_wd;
        bus.tdata1_wmask  = v.t1_wm;
        bus.tdata1_wdata  = v.t1_wd;
        bus.tdata2_wmask  = v.t2_wm;
        bus.tdata2_wdata  = v.t2_wd;
        bus.trigger_fire  = v.fire;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic chk_all_reset(input string nm);
        chk({nm, "_tsel"}, 0, bus.tselect_o, Z);
        for (int i = 0; i < NT; i++) begin
            chk({nm, "_t1"}, i, bus.tdata1_array[i], RST1);
            chk({nm, "_t2"}, i, bus.tdata2_array[i], Z);
        end
        chk({nm, "_mis"}, 0, 32'(bus.csr_mismatch), Z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t hv;
        //           v  t  d  tsel_wm  tsel_wd  t1_wm  t1_wd           t2_wm          t2_wd           fire  idx tsel  exp_t1          exp_t2
        vecs[0]  = mk(1, 0, 1, F, 32'd1,  Z, Z,              Z,             Z,              4'h0, 1, 1, RST1,           Z);
        vecs[1]  = mk(1, 0, 1, Z, Z,      F, 32'h6800_1044,  Z,             Z,              4'h0, 1, 1, 32'h6800_1044,  Z);
        vecs[2]  = mk(1, 0, 1, F, 32'h10, Z, Z,              Z,             Z,              4'h0, 1, 1, 32'h6800_1044,  Z);
        vecs[3]  = mk(1, 0, 1, Z, Z,      F, 32'h3000_0000,  Z,             Z,              4'h0, 1, 1, 32'hF800_0000,  Z);
        vecs[4]  = mk(1, 0, 0, Z, Z,      F, 32'h6800_1044,  Z,             Z,              4'h0, 1, 1, 32'hF800_0000,  Z);
        vecs[5]  = mk(1, 1, 1, Z, Z,      F, 32'h6800_1044,  Z,             Z,              4'h0, 1, 1, 32'hF800_0000,  Z);
        vecs[6]  = mk(1, 0, 1, Z, Z,      Z, Z,              F,             32'hDEAD_BEEF,  4'h0, 1, 1, 32'hF800_0000,  32'hDEAD_BEEF);
        vecs[7]  = mk(1, 0, 1, Z, Z,      F, 32'h2800_1BC4,  Z,             Z,              4'h0, 1, 1, 32'h2800_1044,  32'hDEAD_BEEF);
        vecs[8]  = mk(1, 0, 1, Z, Z,      F, 32'h5000_0241,  Z,             Z,              4'h0, 1, 1, 32'h5800_0241,  32'hDEAD_BEEF);
        vecs[9]  = mk(1, 0, 0, Z, Z,      Z, Z,              Z,             Z,              4'h2, 1, 1, 32'h5C00_0241,  32'hDEAD_BEEF);
        vecs[10] = mk(1, 0, 1, Z, Z,      Z, Z,              32'h0000_FFFF, 32'h1234_5678,  4'h0, 1, 1, 32'h5C00_0241,  32'hDEAD_5678);
        vecs[11] = mk(1, 0, 1, F, Z,      F, 32'h6800_1044,  Z,             Z,              4'h0, 1, 0, 32'h6800_1044,  32'hDEAD_5678);
        vecs[12] = mk(1, 0, 1, Z, Z,      F, 32'h6800_1044,  Z,             Z,              4'h0, 0, 0, 32'h6800_1044,  Z);
        vecs[13] = mk(1, 0, 0, Z, Z,      Z, Z,              Z,             Z,              4'h1, 0, 0, 32'h6840_1044,  Z);
        vecs[14] = mk(1, 0, 1, Z, Z,      F, 32'h6800_1045,  Z,             Z,              4'h1, 0, 0, 32'h6800_1045,  Z);
        vecs[15] = mk(1, 0, 1, Z, Z,      F, F,              Z,             Z,              4'h0, 0, 0, 32'hF800_0000,  Z);
        vecs[16] = mk(1, 0, 0, Z, Z,      Z, Z,              Z,             Z,              4'h1, 0, 0, 32'hF800_0000,  Z);
        vecs[17] = mk(1, 0, 0, F, 32'd3,  Z, Z,              Z,             Z,              4'h0, 3, 3, RST1,           Z);
        vecs[18] = mk(1, 0, 0, F, 32'd4,  Z, Z,              Z,             Z,              4'h0, 3, 3, RST1,           Z);
        vecs[19] = mk(1, 0, 0, 32'd1, Z,  Z, Z,              Z,             Z,              4'h0, 2, 2, RST1,           Z);
        vecs[20] = mk(0, 0, 1, Z, Z,      F, 32'h6800_1044,  Z,             Z,              4'h0, 2, 2, RST1,           Z);
        vecs[21] = mk(1, 0, 1, Z, Z,      32'h0000_0780, 32'h0000_0100, Z, Z,            4'h0, 2, 2, 32'h2800_1100,  Z);

        // Reset and idle
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all_reset("idle");

        // Table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            $display("vec %0d: tsel=%h t1[%0d]=%h t2[%0d]=%h", i, bus.tselect_o,
                     vecs[i].idx, bus.tdata1_array[vecs[i].idx],
                     vecs[i].idx, bus.tdata2_array[vecs[i].idx]);
            chk("tsel", i, bus.tselect_o, vecs[i].exp_tsel);
            chk("tdata1", i, bus.tdata1_array[vecs[i].idx], vecs[i].exp_t1);
            chk("tdata2", i, bus.tdata2_array[vecs[i].idx], vecs[i].exp_t2);
        end

        // Slot isolation: every trigger holds only what was written to it
        $display("iso: t1=%h %h %h %h", bus.tdata1_array[0], bus.tdata1_array[1],
                 bus.tdata1_array[2], bus.tdata1_array[3]);
        chk("iso_t1", 0, bus.tdata1_array[0], 32'hF800_0000);
        chk("iso_t1", 1, bus.tdata1_array[1], 32'h6800_1044);
        chk("iso_t1", 3, bus.tdata1_array[3], RST1);
        chk("iso_t2", 0, bus.tdata2_array[0], Z);
        chk("iso_t2", 1, bus.tdata2_array[1], 32'hDEAD_5678);

        // Async reset mid-cycle with a write pending: cleared before any edge
        bus.rvfi_valid    = 1'b1;
        bus.rvfi_dbg_mode = 1'b1;
        bus.tdata1_wmask  = F;
        bus.tdata1_wdata  = 32'h6800_1044;
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: tsel=%h t1[1]=%h", bus.tselect_o, bus.tdata1_array[1]);
        chk_all_reset("async_rst");
        @(posedge clk);
        #1;
        chk_all_reset("held_rst");
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_t1", 2, bus.tdata1_array[2], RST1);

        // Latency: a write is not visible until the retiring edge
        bus.rvfi_valid    = 1'b1;
        bus.rvfi_dbg_mode = 1'b1;
        bus.tdata1_wmask  = F;
        bus.tdata1_wdata  = 32'h6800_1044;
        #3;
        chk("pre_edge_t1", 0, bus.tdata1_array[0], RST1);
        @(posedge clk);
        #1;
        idle();
        $display("latency: t1[0]=%h", bus.tdata1_array[0]);
        chk("post_edge_t1", 0, bus.tdata1_array[0], 32'h6800_1044);

`ifdef UVMT_CV32E40S_SL_TRIGGER_CSR_CHECK_EN
        // Matching read: no pulse
        hv = mk(1, 0, 1, Z, Z, Z, Z, Z, Z, 4'h0, 0, 0, 32'h6800_1044, Z);
        bus.tdata1_rdata = 32'h6800_1044;
        bus.rvfi_valid = 1'b1;
        bus.rvfi_dbg_mode = 1'b1;
        @(posedge clk);
        #1;
        idle();
        $display("check match: mismatch=%b", bus.csr_mismatch);
        chk("mis_equal", 0, 32'(bus.csr_mismatch), Z);
        // Differing read: exactly one cycle of mismatch
        bus.tdata1_rdata = 32'h1234_5678;
        bus.rvfi_valid = 1'b1;
        bus.rvfi_dbg_mode = 1'b1;
        @(posedge clk);
        #1;
        idle();
        $display("check differ: mismatch=%b", bus.csr_mismatch);
        chk("mis_pulse", 0, 32'(bus.csr_mismatch), 32'd1);
        @(posedge clk);
        #1;
        chk("mis_clear", 0, 32'(bus.csr_mismatch), Z);
        chk("mis_shadow", 0, bus.tdata1_array[0], hv.exp_t1);
`else
        hv = mk(1, 0, 1, Z, Z, Z, Z, Z, Z, 4'h0, 0, 0, 32'h6800_1044, Z);
        bus.tdata1_rdata = 32'h1234_5678;
        bus.rvfi_valid = 1'b1;
        bus.rvfi_dbg_mode = 1'b1;
        @(posedge clk);
        #1;
        idle();
        $display("check disabled: mismatch=%b", bus.csr_mismatch);
        chk("mis_off", 0, 32'(bus.csr_mismatch), Z);
        chk("mis_shadow", 0, bus.tdata1_array[0], hv.exp_t1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
